// File: rtl/vram_scroll_engine_pkg.sv
// Shared definitions for the text-mode VRAM clear/scroll engine:
// video-bus widths, command opcodes, FSM encoding and screen geometry.
package vram_scroll_engine_pkg;

    // Video-bus widths
    localparam int VB_ADDR_W = 12;
    localparam int VB_DATA_W = 32;
    localparam int VB_SEL_W  = 4;

    // Default screen geometry (characters)
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    // cmd_op encodings; the remaining two codes are no-ops
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;
    localparam logic [1:0] OP_NOP3   = 2'b11;

    // Engine FSM states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_FILL = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    // Word index to byte address on the video bus
    function automatic logic [VB_ADDR_W-1:0] word_to_byte(input logic [9:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/vram_scroll_engine.sv
// Text screen clear / scroll-up engine sharing one video-RAM port with the CPU.
// The CPU always wins the port; the engine stalls (or retries a read) when
// it loses. Words are 4 characters; a scroll copies word dst+LINE to dst,
// then fills the last line with the latched fill character.
module vram_scroll_engine
    import vram_scroll_engine_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_ce,
    input  logic                 cpu_we,
    input  logic [VB_ADDR_W-1:0] cpu_addr,
    input  logic [VB_SEL_W-1:0]  cpu_sel,
    input  logic [VB_DATA_W-1:0] cpu_data_i,
    output logic [VB_DATA_W-1:0] cpu_data_o,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    input  logic [7:0]           cmd_fill,
    output logic                 busy,
    output logic                 done,
    output logic                 vram_ce,
    output logic                 vram_we,
    output logic [VB_ADDR_W-1:0] vram_addr,
    output logic [VB_SEL_W-1:0]  vram_sel,
    output logic [VB_DATA_W-1:0] vram_data_o,
    input  logic [VB_DATA_W-1:0] vram_data_i
);

    localparam logic [9:0] LINE_WORDS  = 10'(COLS / 4);
    localparam logic [9:0] SCREEN_LAST = 10'((ROWS * COLS / 4) - 1);
    // Last destination word of the copy phase; the final line is filled
    localparam logic [9:0] COPY_LAST   = 10'((ROWS * COLS / 4) - (COLS / 4) - 1);

    logic [2:0]           r_state;
    logic [9:0]           r_dst;
    logic [VB_DATA_W-1:0] r_hold;
    logic [7:0]           r_fill;

    logic                 w_grant;
    logic                 w_eng_ce;
    logic                 w_eng_we;
    logic [VB_ADDR_W-1:0] w_eng_addr;
    logic [VB_DATA_W-1:0] w_eng_data;

    assign w_grant    = !cpu_ce;
    assign cpu_data_o = vram_data_i;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FIN);

    // Engine port request; suppressed during reset so an abandoned
    // operation cannot land one more write on the reset edge
    always_comb begin
        w_eng_ce   = 1'b0;
        w_eng_we   = 1'b0;
        w_eng_addr = '0;
        w_eng_data = '0;
        case (r_state)
            ST_RD, ST_RDW: begin
                w_eng_ce   = 1'b1;
                w_eng_addr = word_to_byte(r_dst + LINE_WORDS);
            end
            ST_WR: begin
                w_eng_ce   = 1'b1;
                w_eng_we   = 1'b1;
                w_eng_addr = word_to_byte(r_dst);
                w_eng_data = r_hold;
            end
            ST_FILL: begin
                w_eng_ce   = 1'b1;
                w_eng_we   = 1'b1;
                w_eng_addr = word_to_byte(r_dst);
                w_eng_data = {4{r_fill}};
            end
            default: ;
        endcase
        if (rst) begin
            w_eng_ce = 1'b0;
            w_eng_we = 1'b0;
        end
    end

    // Port mux: CPU has absolute priority, otherwise the engine request
    always_comb begin
        vram_ce     = w_eng_ce;
        vram_we     = w_eng_we;
        vram_addr   = w_eng_addr;
        vram_sel    = w_eng_ce ? {VB_SEL_W{1'b1}} : '0;
        vram_data_o = w_eng_data;
        if (cpu_ce) begin
            vram_ce     = 1'b1;
            vram_we     = cpu_we;
            vram_addr   = cpu_addr;
            vram_sel    = cpu_sel;
            vram_data_o = cpu_data_i;
        end
    end

    // Engine FSM. Port-using states stall without the grant; CAP and FIN
    // never touch the port and always advance (CAP must sample the read
    // data in the one cycle it is valid, FIN must stay a single pulse).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dst   <= '0;
            r_hold  <= '0;
            r_fill  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && (cmd_op == OP_CLEAR || cmd_op == OP_SCROLL)) begin
                        r_fill  <= cmd_fill;
                        r_dst   <= '0;
                        r_state <= (cmd_op == OP_CLEAR) ? ST_FILL : ST_RD;
                    end
                end
                ST_RD: begin
                    if (w_grant) r_state <= ST_RDW;
                end
                ST_RDW: begin
                    // Losing the second address cycle breaks the read; retry
                    r_state <= w_grant ? ST_CAP : ST_RD;
                end
                ST_CAP: begin
                    r_hold  <= vram_data_i;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (w_grant) begin
                        r_dst   <= r_dst + 10'd1;
                        r_state <= (r_dst == COPY_LAST) ? ST_FILL : ST_RD;
                    end
                end
                ST_FILL: begin
                    if (w_grant) begin
                        if (r_dst == SCREEN_LAST) r_state <= ST_FIN;
                        else                      r_dst   <= r_dst + 10'd1;
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vram_scroll_engine.md
VRAM_SCROLL_ENGINE -- requirements
Module: vram_scroll_engine

Interface
REQ-001 SHALL have parameters: COLS, default 80, characters per text line; ROWS, default 30, text lines; line = COLS/4 words (20), screen = ROWS*COLS/4 words (600).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cpu_ce, cpu_we  in  1 each  CPU video-RAM chip enable and write enable.
REQ-005 cpu_addr  in  12  CPU byte address; cpu_sel  in  4  byte lane enables; cpu_data_i  in  32  CPU write data.
REQ-006 cpu_data_o  out  32  CPU read data, combinational pass-through of vram_data_i.
REQ-007 cmd_valid  in  1  command strobe; cmd_op  in  2  01 clear screen, 10 scroll up one line, 00/11 no-op; cmd_fill  in  8  fill character.
REQ-008 busy  out  1  engine executing; done  out  1  one-cycle pulse on command completion.
REQ-009 vram_ce, vram_we  out  1 each; vram_addr  out  12; vram_sel  out  4; vram_data_o  out  32: muxed video-RAM port.
REQ-010 vram_data_i  in  32  video-RAM registered read data, valid 2 cycles after a read address, provided ce=1/we=0 is held in both cycles.

Function
REQ-011 Arbitration SHALL be combinational, CPU priority: when cpu_ce=1, all vram_* outputs SHALL equal the cpu_* inputs and the engine SHALL not advance that cycle.
REQ-012 When cpu_ce=0 and engine is idle, vram_ce SHALL be 0.
REQ-013 Engine FSM states SHALL be IDLE, RD, RDW, CAP, WR, FILL, FIN.
REQ-014 In IDLE, cmd_valid=1 with op 01 SHALL go to FILL with dst=0; op 10 SHALL go to RD with dst=0; ops 00/11 SHALL be ignored; cmd_valid while busy SHALL be ignored.
REQ-015 RD: drive ce=1, we=0, addr=(dst+line)*4; if granted go RDW, else stay in RD.
REQ-016 RDW: drive the same address with ce=1, we=0; if granted go CAP, else return to RD (read retried).
REQ-017 CAP: no port access; capture vram_data_i into a 32-bit hold register; go WR.
REQ-018 WR: drive ce=1, we=1, sel=1111, addr=dst*4, data=hold; if granted, dst+1; when dst reaches screen-line, go FILL; otherwise go RD; if not granted, stay in WR.
REQ-019 FILL: write {4{cmd_fill latched at acceptance}} to dst*4 with sel=1111; if granted, dst+1; after writing word screen-1, go FIN.
REQ-020 FIN: done=1 for exactly one cycle, then IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE, including FIN.
REQ-022 dst SHALL be a 10-bit counter; it SHALL never exceed screen-1, and no address ≥ screen*4 SHALL be driven.
REQ-023 Uncontended durations: clear SHALL take 600 FILL cycles + 1 FIN; scroll SHALL take 580×4 + 20 + 1 cycles from the cycle after acceptance.
REQ-024 CPU writes to the screen during an operation SHALL be permitted; their final effect is undefined only for words not yet processed by the engine.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, dst=0, hold=0, latched fill=0, busy=0, done=0; an in-progress operation SHALL be abandoned with no further engine writes.
REQ-026 vram_* outputs SHALL follow REQ-011/012 during reset (CPU pass-through remains).

Structure
REQ-027 Shared package SHALL hold the cmd_op encodings, FSM state encoding and the default COLS/ROWS constants; address, data and byte-width macros SHALL be the existing video-bus definitions.
REQ-028 Implementation SHALL be a single module with no sub-modules; the video RAM is instantiated by the parent.

Verification
REQ-029 Clear with fill 0x20, no CPU traffic -> words 0..599 = 0x20202020, busy for 601 cycles, one done pulse.
REQ-030 Scroll with word w preloaded to w -> word w = w+20 for w<580, words 580..599 = fill, done after 2341 cycles.
REQ-031 Scroll with cpu_ce pulsed in an RDW cycle -> read retried, no corrupted word, completion delayed by the stolen cycles.
REQ-032 cmd_valid with op 10 while busy during clear -> ignored, only one done pulse.
REQ-033 rst asserted at dst=300 of a clear -> busy=0 next cycle, words 300..599 unchanged.
REQ-034 CPU read of word 5 during clear (word 5 already filled) -> cpu_data_o = fill pattern 2 cycles later.
